// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz result transmitter and the host-side decoder model.
// Build option: COLLATZ_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } tx_state_t;

  // Upper seven header bits; the LSB carries the overflow flag.
  localparam logic [6:0] HDR_BASE = 7'b1010010;

  // Bytes per frame: header, step count, peak value, optional checksum.
  function automatic int frame_len(input int steps_w, input int peak_w);
`ifdef COLLATZ_TX_CHECKSUM_EN
    return 2 + steps_w / 8 + peak_w / 8;
`else
    return 1 + steps_w / 8 + peak_w / 8;
`endif
  endfunction

endpackage

// File: rtl/collatz_ack_sync.sv
// Two-flop synchroniser for the reader's asynchronous acknowledge.
module collatz_ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [1:0] sync_pipe;

  // Shift the raw input through two flops; only the second stage is consumed.
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= 2'b00;
    else     sync_pipe <= {sync_pipe[0], async_in};
  end

  assign sync_out = sync_pipe[1];

endmodule

// File: rtl/collatz_result_tx.sv
// Collatz result transmitter: latches one result and streams it as a byte frame
// {hdr, steps LSB-first, peak LSB-first} over a four-phase req/ack handshake.
// Build option: COLLATZ_TX_CHECKSUM_EN adds a trailing XOR-of-all-bytes checksum.
module collatz_result_tx
  import collatz_pkg::*;
#(
  parameter int STEPS_W = 16,
  parameter int PEAK_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [STEPS_W-1:0] res_steps,
  input  logic [PEAK_W-1:0]  res_peak,
  input  logic               res_ovf,
  output logic [7:0]         tx_data,
  output logic               tx_req,
  input  logic               tx_ack,
  output logic               busy
);

  localparam int DATA_LEN  = 1 + STEPS_W / 8 + PEAK_W / 8;
  localparam int FRAME_LEN = frame_len(STEPS_W, PEAK_W);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_t             state;
  logic [DATA_LEN*8-1:0] frame_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [7:0]            next_byte;
  logic                  ack_s;
`ifdef COLLATZ_TX_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  collatz_ack_sync u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (tx_ack),
    .sync_out (ack_s)
  );

  // A stale ack from the previous frame blocks new results until it clears.
  assign res_ready = (state == IDLE) && !ack_s;
  assign idx_nxt   = idx + 1'b1;

  // Byte that follows the current one: a latched frame byte, or the checksum.
  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < DATA_LEN; i++)
      if (idx_nxt == IDX_W'(i)) next_byte = frame_q[i*8 +: 8];
`ifdef COLLATZ_TX_CHECKSUM_EN
    if (idx_nxt == IDX_W'(DATA_LEN)) next_byte = csum ^ tx_data;
`endif
  end

  // Handshake FSM; tx_data only moves while req and ack_s are both low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      frame_q <= '0;
      tx_req  <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
`ifdef COLLATZ_TX_CHECKSUM_EN
      csum    <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (res_valid && res_ready) begin
            frame_q <= {res_peak, res_steps, HDR_BASE, res_ovf};
            idx     <= '0;
            tx_data <= {HDR_BASE, res_ovf};
            tx_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
`ifdef COLLATZ_TX_CHECKSUM_EN
            csum    <= 8'h00;
`endif
          end
        end
        SEND: begin
          if (ack_s) begin
            tx_req <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx     <= idx_nxt;
              tx_data <= next_byte;
              tx_req  <= 1'b1;
              state   <= SEND;
`ifdef COLLATZ_TX_CHECKSUM_EN
              csum    <= csum ^ tx_data;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_result_tx.sv
// Directed bench for collatz_result_tx: reset, frame contents, stale ack,
// slow reader, back-to-back results, mid-frame reset.
module tb_collatz_result_tx;

`ifdef COLLATZ_TX_CHECKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_steps;
  logic [31:0] res_peak;
  logic        res_ovf;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Bench-side model of the two-flop ack synchroniser.
  logic a1 = 1'b0, acks = 1'b0;
  logic prev_req = 1'b0, prev_acks = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] e [8];
  int nw;

  collatz_result_tx #(.STEPS_W(16), .PEAK_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_steps (res_steps),
    .res_peak  (res_peak),
    .res_ovf   (res_ovf),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_ack    (tx_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      a1   <= 1'b0;
      acks <= 1'b0;
    end else begin
      a1   <= tx_ack;
      acks <= a1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and police the handshake rules.
  task automatic tick();
    @(negedge clk);
    if (!rst && !prev_rst) begin
      if (prev_req || prev_acks) check("data_stable", tx_data, prev_data);
      if (tx_req && !prev_req) check("req_rise_ack_low", prev_acks, 1'b0);
    end
    prev_req  = tx_req;
    prev_acks = acks;
    prev_data = tx_data;
    prev_rst  = rst;
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (tx_req !== lvl && n < 300) begin tick(); n++; end
    if (tx_req !== lvl) check({tag, "_timeout"}, tx_req, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin tick(); n++; end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic send_result(input logic [15:0] s, input logic [31:0] p, input logic o,
                             input string tag, output int waited);
    int n = 0;
    res_steps = s; res_peak = p; res_ovf = o; res_valid = 1'b1;
    while (res_ready !== 1'b1 && n < 300) begin tick(); n++; end
    waited = n;
    check({tag, "_ready"}, res_ready, 1'b1);
    tick();
    res_valid = 1'b0;
    res_steps = ~s; res_peak = ~p; res_ovf = ~o;
    check({tag, "_req_t1"}, tx_req, 1'b1);
    check({tag, "_hdr"}, tx_data, {7'b1010010, o});
  endtask

  task automatic read_frame(input logic [7:0] exp [8], input int n, input int maxd, input string tag);
    int d;
    for (int i = 0; i < n; i++) begin
      wait_req(1'b1, $sformatf("%s_req%0d", tag, i));
      check($sformatf("%s_b%0d", tag, i), tx_data, exp[i]);
      d = int'($urandom_range(maxd, 0));
      repeat (d) tick();
      tx_ack = 1'b1;
      wait_req(1'b0, $sformatf("%s_rel%0d", tag, i));
      d = int'($urandom_range(maxd, 0));
      repeat (d) tick();
      tx_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; tx_ack = 1'b0;
    res_steps = '0; res_peak = '0; res_ovf = 1'b0;
    repeat (3) tick();
    check("rst_req", tx_req, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_ready", res_ready, 1'b1);

    // 1: reset in the middle of a frame
    e = '{8'hA4, 8'h6F, 8'h00, 8'h10, 8'h24, 8'h00, 8'h00, 8'hFF};
    send_result(16'd111, 32'd9232, 1'b0, "t1", nw);
    read_frame(e, 2, 2, "t1");
    wait_req(1'b1, "t1_b2");
    rst = 1'b1;
    tick();
    check("t1_abort_req", tx_req, 1'b0);
    check("t1_abort_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t1_post_ready", res_ready, 1'b1);
    check("t1_post_busy", busy, 1'b0);
    repeat (10) tick();
    check("t1_discarded", tx_req, 1'b0);

    // 2: full frame, prompt reader, busy falls after last ack low
    send_result(16'd111, 32'd9232, 1'b0, "t2", nw);
    read_frame(e, FLEN, 2, "t2");
    tick();
    check("t2_busy_d1", busy, 1'b1);
    tick();
    check("t2_busy_d2", busy, 1'b1);
    tick();
    check("t2_busy_d3", busy, 1'b0);
    check("t2_req_end", tx_req, 1'b0);

    // 3: all-ones payload with overflow
    e = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5};
    send_result(16'hFFFF, 32'hFFFF_FFFF, 1'b1, "t3", nw);
    read_frame(e, FLEN, 3, "t3");
    wait_idle("t3");

    // 4: stale ack blocks acceptance; valid dropped before accept latches nothing
    tx_ack = 1'b1;
    repeat (4) tick();
    res_steps = 16'd5; res_peak = 32'd16; res_ovf = 1'b0; res_valid = 1'b1;
    repeat (3) tick();
    check("t4_stale_ready", res_ready, 1'b0);
    check("t4_stale_req", tx_req, 1'b0);
    res_valid = 1'b0;
    tick();
    tx_ack = 1'b0;
    tick();
    check("t4_ready_d1", res_ready, 1'b0);
    tick();
    check("t4_ready_d2", res_ready, 1'b1);
    check("t4_no_latch_busy", busy, 1'b0);
    check("t4_no_latch_req", tx_req, 1'b0);
    e = '{8'hA4, 8'h05, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hB1};
    send_result(16'd5, 32'd16, 1'b0, "t4", nw);
    read_frame(e, FLEN, 1, "t4");
    wait_idle("t4");

    // 5: slow, randomised reader
    e = '{8'hA5, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hA1};
    send_result(16'h1234, 32'hDEAD_BEEF, 1'b1, "t5", nw);
    read_frame(e, FLEN, 20, "t5");
    wait_idle("t5");

    // 6: back-to-back results
    e = '{8'hA4, 8'h10, 8'h00, 8'h34, 8'h00, 8'h00, 8'h00, 8'h80};
    send_result(16'd16, 32'd52, 1'b0, "t6a", nw);
    read_frame(e, FLEN, 0, "t6a");
    e = '{8'hA4, 8'h08, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hBC};
    send_result(16'd8, 32'd16, 1'b0, "t6b", nw);
    check("t6_gap", nw, 3);
    read_frame(e, FLEN, 0, "t6b");
    wait_idle("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
